// File: rtl/sipo_deser.sv
// sipo_deser - parametrised serial-in/parallel-out deserializer.
//
// Shifts one serial bit per qualified clock into a WIDTH-bit register and
// counts bits to frame words. Each completed word is presented on a
// registered parallel port with a valid/ready handshake. A completed word
// that cannot be accepted is dropped and flagged on a sticky overflow bit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   a          serial data bit
//   in_valid   a is sampled on this edge only when 1
//   sync_clr   frame realign: bit counter to 0, clears overflow
//   q          live shift register contents
//   bit_cnt    bits collected in the current frame (0..WIDTH-1)
//   out_data   last completed word, registered
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data when out_valid && out_ready
//   overflow   sticky: a completed word was dropped
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             in_valid,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    bit_cnt,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] shifted;
    logic             can_accept;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {q_q[WIDTH-2:0], a};
        end else begin
            shifted = {a, q_q[WIDTH-1:1]};
        end
    end

    // The output register is free if it is empty or is being drained this cycle.
    assign can_accept = !out_valid_q || out_ready;

    always_comb begin
        q_d         = q_q;
        bit_cnt_d   = bit_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // sync_clr wins over a coincident serial bit; the handshake above still runs.
        if (sync_clr) begin
            bit_cnt_d  = '0;
            overflow_d = 1'b0;
        end else if (in_valid) begin
            q_d = shifted;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (can_accept) begin
                    out_data_d  = shifted;
                    out_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q         <= '0;
            bit_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            q_q         <= q_d;
            bit_cnt_q   <= bit_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign q         = q_q;
    assign bit_cnt   = bit_cnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rst_n, a, in_valid, sync_clr, out_ready;

    always #5 clk = ~clk;

    // Three instances share stimulus: W4 MSB-first, W4 LSB-first, W8 MSB-first.
    logic [3:0] q0, q1, od0, od1;
    logic [7:0] q2, od2;
    logic [1:0] bc0, bc1;
    logic [2:0] bc2;
    logic       ov0, ov1, ov2, of0, of1, of2;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) u_w4m (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .sync_clr(sync_clr),
        .q(q0), .bit_cnt(bc0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .overflow(of0));
    sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) u_w4l (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .sync_clr(sync_clr),
        .q(q1), .bit_cnt(bc1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .overflow(of1));
    sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) u_w8m (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .sync_clr(sync_clr),
        .q(q2), .bit_cnt(bc2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .overflow(of2));

    logic [7:0] dq[3], dd[3];
    logic [2:0] dbc[3];
    logic       dv[3], dov[3];
    assign dq[0] = {4'b0, q0};   assign dq[1] = {4'b0, q1};   assign dq[2] = q2;
    assign dd[0] = {4'b0, od0};  assign dd[1] = {4'b0, od1};  assign dd[2] = od2;
    assign dbc[0] = {1'b0, bc0}; assign dbc[1] = {1'b0, bc1}; assign dbc[2] = bc2;
    assign dv[0] = ov0; assign dv[1] = ov1; assign dv[2] = ov2;
    assign dov[0] = of0; assign dov[1] = of1; assign dov[2] = of2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 'h%0h expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  wid[3] = '{4, 4, 8};
    bit  msb[3] = '{1'b1, 1'b0, 1'b1};
    bit  hist[$];              // every sampled serial bit since reset, oldest first
    int  m_cnt[3];
    bit  m_val[3];
    int  m_data[3];
    bit  m_ovf[3];
    bit  cmp_en = 1'b0;

    // Live register view: the most recent WIDTH sampled bits, zero-filled.
    function automatic int view(input int i);
        int r = 0;
        int n = hist.size();
        for (int k = 0; k < wid[i]; k++) begin
            if (k < n && hist[n-1-k]) begin
                if (msb[i]) r |= (1 << k);
                else        r |= (1 << (wid[i] - 1 - k));
            end
        end
        return r;
    endfunction

    task automatic model_step(input bit ra, input bit riv, input bit rsc, input bit rrdy, input bit rrst);
        bit sample = rrst && !rsc && riv;
        if (!rrst) hist.delete();
        else if (sample) hist.push_back(ra);
        for (int i = 0; i < 3; i++) begin
            if (!rrst) begin
                m_cnt[i] = 0; m_val[i] = 0; m_data[i] = 0; m_ovf[i] = 0;
            end else begin
                bit was_val = m_val[i];
                bit done    = sample && (m_cnt[i] == wid[i] - 1);
                if (was_val && rrdy) m_val[i] = 0;
                if (rsc) begin
                    m_cnt[i] = 0; m_ovf[i] = 0;
                end else if (sample) begin
                    m_cnt[i] = (m_cnt[i] + 1) % wid[i];
                end
                if (done) begin
                    if (!was_val || rrdy) begin
                        m_data[i] = view(i); m_val[i] = 1;
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("q[%0d]", i),        int'(dq[i]),  view(i));
                chk($sformatf("bit_cnt[%0d]", i),  int'(dbc[i]), m_cnt[i]);
                chk($sformatf("out_valid[%0d]", i), int'(dv[i]), int'(m_val[i]));
                chk($sformatf("overflow[%0d]", i), int'(dov[i]), int'(m_ovf[i]));
                if (m_val[i]) chk($sformatf("out_data[%0d]", i), int'(dd[i]), m_data[i]);
            end
        end
    end

    task automatic cyc(input bit ba, input bit biv, input bit bsc, input bit brdy, input bit brst);
        a = ba; in_valid = biv; sync_clr = bsc; out_ready = brdy; rst_n = brst;
        @(posedge clk);
        model_step(ba, biv, bsc, brdy, brst);
        cmp_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic bits4(input logic [3:0] b, input bit rdy);
        for (int k = 3; k >= 0; k--) cyc(b[k], 1'b1, 1'b0, rdy, 1'b1);
    endtask

    initial begin
        logic [7:0] byte_a5;
        logic [7:0] stream;
        a = 0; in_valid = 0; sync_clr = 0; out_ready = 0; rst_n = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset_out_data", int'(od0), 0);
        chk("reset_out_valid", int'(ov0), 0);
        chk("reset_q", int'(q2), 0);

        // 1/2: bits 1,0,1,1 with ready high
        bits4(4'b1011, 1'b1);
        chk("t1_out_data_msb", int'(od0), 'b1011);
        chk("t1_out_valid", int'(ov0), 1);
        chk("t1_bit_cnt", int'(bc0), 0);
        chk("t1_q", int'(q0), 'b1011);
        chk("t2_out_data_lsb", int'(od1), 'b1101);
        cyc(0, 0, 0, 1, 1);
        chk("t1_valid_pulse", int'(ov0), 0);

        // 2: gapped input, bits 0,1,0,0
        cyc(0, 1, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        chk("t2_gap_cnt", int'(bc1), 1);
        cyc(1, 1, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        chk("t2_word_lsb", int'(od1), 'b0010);
        chk("t2_word_msb", int'(od0), 'b0100);
        cyc(0, 0, 0, 1, 1);

        // 3: overflow with ready low
        bits4(4'b1011, 1'b0);
        bits4(4'b0110, 1'b0);
        chk("t3_data_held", int'(od0), 'b1011);
        chk("t3_valid_held", int'(ov0), 1);
        chk("t3_overflow", int'(of0), 1);
        cyc(0, 0, 0, 1, 1);
        chk("t3_drained", int'(ov0), 0);
        cyc(0, 0, 1, 0, 1);
        chk("t3_ovf_clr", int'(of0), 0);

        // 4: back-to-back frames
        stream = 8'b1010_0101;
        for (int k = 7; k >= 0; k--) begin
            cyc(stream[k], 1'b1, 1'b0, 1'b1, 1'b1);
            if (k == 4) begin
                chk("t4_pulse1", int'(ov0), 1);
                chk("t4_word1", int'(od0), 'b1010);
            end else if (k == 0) begin
                chk("t4_pulse2", int'(ov0), 1);
                chk("t4_word2", int'(od0), 'b0101);
            end else begin
                chk("t4_no_pulse", int'(ov0), 0);
            end
        end

        // 5: reset mid-frame
        cyc(1, 1, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        chk("t5_q", int'(q0), 0);
        chk("t5_cnt", int'(bc0), 0);
        chk("t5_data", int'(od0), 0);
        chk("t5_valid", int'(ov0), 0);
        bits4(4'b1100, 1'b1);
        chk("t5_word", int'(od0), 'b1100);

        // 6: sync_clr beats a coincident bit
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        cyc(1, 1, 1, 1, 1);
        chk("t6_cnt", int'(bc0), 0);
        chk("t6_q", int'(q0), 'b0101);
        chk("t6_no_valid", int'(ov0), 0);
        cyc(0, 0, 0, 1, 0);
        byte_a5 = 8'hA5;
        for (int k = 7; k >= 0; k--) cyc(byte_a5[k], 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_w8_byte", int'(od2), 'hA5);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 199) != 0));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
